// File: rtl/lsu_align.sv
// Load/store alignment unit: byte-addressed requests become one or two word accesses.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses; otherwise misalignment faults.
module lsu_align #(
    parameter int unsigned N = 12
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_we,
    input  logic [2:0]   i_funct3,
    input  logic [31:0]  i_addr,
    input  logic [31:0]  i_wdata,
    output logic         o_done,
    output logic [31:0]  o_rdata,
    output logic         o_fault,
    output logic [N-1:0] o_mem_addr,
    output logic         o_mem_we,
    output logic [3:0]   o_mem_be,
    output logic [31:0]  o_mem_wdata,
    input  logic [31:0]  i_mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    function automatic logic [3:0] size_mask(input logic [1:0] f);
        case (f)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    state_e       r_state;
    state_e       w_state_d;
    logic         r_we;
    logic [2:0]   r_funct3;
    logic [1:0]   r_off;
    logic [N-1:0] r_waddr;
    logic [31:0]  r_wdata;
    logic         r_req_fault;
    logic         r_cross;
    logic [31:0]  r_w0;
    logic         r_done;
    logic [31:0]  r_rdata;
    logic         r_resp_fault;

    logic         w_in_illegal;
    logic         w_in_cross;
    logic         w_in_fault;
    logic         w_unused_addr;

    assign w_in_illegal = (i_funct3[1:0] == 2'b11) || (i_funct3[2] && (i_we || i_funct3[1]));

`ifdef MISALIGN_SPLIT_EN
    logic [7:0] w_in_lanes;
    assign w_in_lanes = {4'b0000, size_mask(i_funct3[1:0])} << i_addr[1:0];
    assign w_in_cross = |w_in_lanes[7:4];
    assign w_in_fault = w_in_illegal;
`else
    // Without splitting, any address not a multiple of the access size faults.
    logic w_in_misal;
    assign w_in_misal = |(i_addr[1:0] & {i_funct3[1], i_funct3[1] | i_funct3[0]});
    assign w_in_cross = 1'b0;
    assign w_in_fault = w_in_illegal | w_in_misal;
`endif

    assign w_unused_addr = ^i_addr[31:N+2];

    logic [3:0]  w_size_mask;
    logic [7:0]  w_lanes;
    logic [31:0] w_wmask;
    logic [63:0] w_st;
    logic [63:0] w_ld;
    logic [31:0] w_ld_sh;
    logic [31:0] w_ld_ext;

    assign w_size_mask = size_mask(r_funct3[1:0]);
    assign w_lanes     = {4'b0000, w_size_mask} << r_off;
    assign w_wmask     = {{8{w_size_mask[3]}}, {8{w_size_mask[2]}},
                          {8{w_size_mask[1]}}, {8{w_size_mask[0]}}};
    assign w_st        = {32'h0, r_wdata & w_wmask} << {r_off, 3'b000};
    // In RESP the bus holds the last word read: w1 for a split access, w0 otherwise.
    assign w_ld        = r_cross ? {i_mem_rdata, r_w0} : {32'h0, i_mem_rdata};
    assign w_ld_sh     = w_ld[{r_off, 3'b000} +: 32];

    always_comb begin
        case (r_funct3)
            3'b000:  w_ld_ext = {{24{w_ld_sh[7]}}, w_ld_sh[7:0]};
            3'b001:  w_ld_ext = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
            3'b100:  w_ld_ext = {24'h0, w_ld_sh[7:0]};
            3'b101:  w_ld_ext = {16'h0, w_ld_sh[15:0]};
            default: w_ld_ext = w_ld_sh;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (i_valid) w_state_d = w_in_fault ? StResp : StAcc0;
            StAcc0:  w_state_d = r_cross ? StAcc1 : StResp;
            StAcc1:  w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        o_mem_be = 4'b0000;
        case (r_state)
            StAcc0:  o_mem_be = w_lanes[3:0];
            StAcc1:  o_mem_be = w_lanes[7:4];
            default: o_mem_be = 4'b0000;
        endcase
    end

    assign o_ready     = (r_state == StIdle);
    assign o_mem_addr  = (r_state == StAcc1) ? r_waddr + N'(1) : r_waddr;
    assign o_mem_we    = r_we && ((r_state == StAcc0) || (r_state == StAcc1));
    assign o_mem_wdata = (r_state == StAcc1) ? w_st[63:32] : w_st[31:0];
    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_fault     = r_resp_fault;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_done       <= 1'b0;
            r_rdata      <= 32'h0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_done  <= (r_state == StResp);
            if (r_state == StResp) begin
                r_rdata      <= (r_req_fault || r_we) ? 32'h0 : w_ld_ext;
                r_resp_fault <= r_req_fault;
            end
        end
    end

    // Request fields and first read word are pure datapath and need no reset.
    always_ff @(posedge i_clk) begin
        if ((r_state == StIdle) && i_valid) begin
            r_we        <= i_we;
            r_funct3    <= i_funct3;
            r_off       <= i_addr[1:0];
            r_waddr     <= i_addr[N+1:2];
            r_wdata     <= i_wdata;
            r_req_fault <= w_in_fault;
            r_cross     <= w_in_cross;
        end
        if (r_state == StAcc1) begin
            r_w0 <= i_mem_rdata;
        end
    end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the execute stage and the word-organised data memory of the RISC-V core. It accepts one byte-addressed load or store with a RISC-V funct3 size/sign code and converts it into one or two word accesses with byte enables. For loads it extracts the addressed bytes from the returned word(s) and sign- or zero-extends them. Completion is reported as a one-cycle pulse with the load result.

## Interface
- N, 12: word-address width of the data memory (2^N words of 32 bits).
- i_clk, in, 1: clock; all state updates on its rising edge.
- i_rst, in, 1: synchronous, active-high reset.
- i_valid, in, 1: request present; sampled only when o_ready=1.
- o_ready, out, 1: unit idle and able to accept a request.
- i_we, in, 1: 1 = store, 0 = load.
- i_funct3, in, 3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only for stores.
- i_addr, in, 32: byte address.
- i_wdata, in, 32: store data, right-aligned.
- o_done, out, 1: one-cycle completion pulse, registered.
- o_rdata, out, 32: load result, valid with o_done; 0 for stores and faults.
- o_fault, out, 1: illegal funct3 or unsupported misalignment, valid with o_done.
- o_mem_addr, out, N: word address, i_addr[N+1:2] (+1 for second access, modulo 2^N).
- o_mem_we, out, 1: memory write strobe.
- o_mem_be, out, 4: byte-lane enables, bit k = bits 8k+7:8k.
- o_mem_wdata, out, 32: lane-aligned write data.
- i_mem_rdata, in, 32: memory read data, valid one cycle after the address is presented (synchronous read).

## Operation
- Size s = 1/2/4 bytes from funct3[1:0]; off = i_addr[1:0]; little-endian.
- 8-bit lane mask = ((1<<s)-1) << off; bits 3:0 → first word, bits 7:4 → second word. Crossing = mask[7:4] != 0.
- Store data: {32'b0, size-masked i_wdata} << 8*off; low half → first word, high half → second word.
- Load: {w1, w0} >> 8*off, truncated to s bytes; sign-extend if funct3[2]=0, zero-extend otherwise; W ignores funct3[2] (BU/HU only).
- Illegal: funct3 011/110/111, or store with funct3[2]=1 → o_fault=1, no memory write, o_rdata=0.
- Address bits above N+1 are ignored.
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE: o_ready=1, o_mem_we=0, o_mem_be=0. When i_valid=1, latch the request and go to ACC0. If the request faults, go straight to RESP with no memory access.
  - ACC0: drive first word (addr, be, wdata, we=i_we). Go to ACC1 if crossing, else RESP.
  - ACC1: drive second word at addr+1. Capture i_mem_rdata as w0. Go to RESP.
  - RESP: memory idle. Last read word is on i_mem_rdata (w0 if aligned, w1 if split). Register o_rdata/o_fault, set o_done for the next cycle, and return to IDLE.
- Requests while o_ready=0 are ignored; the requester holds i_valid.

## Timing
- Reset: state IDLE, o_done=0, o_rdata=0, o_fault=0, memory strobes 0.
- Acceptance edge E0; single access: ACC0 in cycle 1, RESP in cycle 2, o_done high in cycle 3 (IDLE).
- Split access: o_done high in cycle 4. Fault: o_done high in cycle 2.
- A new request may be accepted in the cycle o_done is high.
- Memory signals are combinational from the state and latched request; they are stable for the whole access cycle.
- Reset mid-operation: next cycle IDLE, no o_done.
  - A write already presented at the reset edge is still committed by the memory, which has no reset.
  - Reset in ACC1 of a split store leaves the first word written.

## Configuration
- MISALIGN_SPLIT_EN defined: crossing accesses are split into ACC0+ACC1. Misaligned non-crossing accesses (e.g. LH at off=1) complete in one access.
- Undefined: any access with i_addr not a multiple of s faults (o_fault=1, no memory access), and the ACC1 state is unreachable.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 → word 0x40, be=1111, o_rdata=0xDEADBEEF, o_done 3 cycles after acceptance.
- SB 0x80 @0x103 → be=1000, wdata=0x80000000; LB @0x103 → 0xFFFFFF80; LBU → 0x00000080.
- MISALIGN_SPLIT_EN: SW 0x11223344 @0x102 → word 0x40 be=1100 data 0x33440000, word 0x41 be=0011 data 0x00001122; LW @0x102 → 0x11223344, o_done after 4 cycles.
- Macro undefined: LH @0x101 → o_fault=1, o_rdata=0, o_mem_we never asserted. Also: funct3=011 load → o_fault=1.
- MISALIGN_SPLIT_EN, N=12: LW @0x3FFE → second access at word 0x000.
- Reset during ACC1 of a split load → next cycle IDLE, o_ready=1, o_done=0, o_rdata=0.
